// File: rtl/sd_fetch_cntl_if.sv
// Bundles the requester handshake, the sd_memory read port and the tagged entry
// outputs of the storage-descriptor fetch controller.
interface sd_fetch_cntl_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 10
);
  localparam int TAG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]        xx__sdf__req_valid;
  logic [NUM_REQ*ADDR_W-1:0] xx__sdf__req_ptr;
  logic [NUM_REQ-1:0]        sdf__xx__req_ready;
  logic                      sdf__sdm__read;
  logic [ADDR_W-1:0]         sdf__sdm__addr;
  logic                      sdm__sdf__valid;
  logic [1:0]                sdm__sdf__dcntl;
  logic                      sdf__xx__valid;
  logic [TAG_W-1:0]          sdf__xx__tag;
  logic                      sdf__xx__last;
  logic                      sdf__xx__err;

  // Fetch controller side
  modport slave (
    input  xx__sdf__req_valid, xx__sdf__req_ptr, sdm__sdf__valid, sdm__sdf__dcntl,
    output sdf__xx__req_ready, sdf__sdm__read, sdf__sdm__addr,
           sdf__xx__valid, sdf__xx__tag, sdf__xx__last, sdf__xx__err
  );

  // Requesters / memory / decoder side
  modport master (
    output xx__sdf__req_valid, xx__sdf__req_ptr, sdm__sdf__valid, sdm__sdf__dcntl,
    input  sdf__xx__req_ready, sdf__sdm__read, sdf__sdm__addr,
           sdf__xx__valid, sdf__xx__tag, sdf__xx__last, sdf__xx__err
  );
endinterface

// File: rtl/sd_fetch_cntl.sv
// Storage-descriptor fetch controller: round-robin grants one descriptor at a
// time, streams speculative reads from its start pointer, qualifies returned
// entries and squashes reads issued past the end of the descriptor.
//
//   state | meaning
//   IDLE  | waiting for a request; grants and latches ptr/tag
//   ISSUE | one read per cycle from ptr upward until the end is seen or MAX_LEN reads
//   DRAIN | no reads; waits for last entry and all in-flight responses
module sd_fetch_cntl #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 10,
  parameter int MAX_LEN = 16,
  parameter int RD_LAT  = 2
) (
  input logic            clk,
  input logic            reset_poweron,
  sd_fetch_cntl_if.slave bus
);

  localparam int TAG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_LEN + 1);
  localparam int IDX_W = $clog2(MAX_LEN);
  localparam int IFL_W = $clog2(RD_LAT + 2);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam logic [1:0] DC_EOM = 2'b10;

  logic [1:0]        state_q, state_d;
  logic [TAG_W-1:0]  rr_q, rr_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IFL_W-1:0]  ifl_q, ifl_d;
  logic [RD_LAT-1:0] live_q, live_d;
  logic              done_q, done_d;

  logic [ADDR_W-1:0] req_ptr_a [NUM_REQ];
  logic [TAG_W:0]    rr_sum;
  logic              gnt_any;
  logic [TAG_W-1:0]  gnt_idx;
  logic              grant;
  logic              live_now;
  logic              last_e;
  logic              err_e;
  logic              last_now;
  logic              err_now;
  logic              issue;

  // Unpack the flat per-requester pointer bus
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ptr_a[i] = bus.xx__sdf__req_ptr[i*ADDR_W +: ADDR_W];
    end
  end

  // Round-robin search: first valid requester at or after rr_q
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = rr_q;
    rr_sum  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      rr_sum = {1'b0, rr_q} + (TAG_W+1)'(k);
      if (rr_sum >= (TAG_W+1)'(NUM_REQ)) begin
        rr_sum = rr_sum - (TAG_W+1)'(NUM_REQ);
      end
      if (!gnt_any && bus.xx__sdf__req_valid[rr_sum[TAG_W-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = rr_sum[TAG_W-1:0];
      end
    end
  end

  // Grants are held off while reset is asserted so every output reads 0
  assign grant = reset_poweron && (state_q == IDLE) && gnt_any;

  // Qualify and classify the entry returning this cycle
  always_comb begin
    live_now = bus.sdm__sdf__valid & live_q[RD_LAT-1];
    err_e    = 1'b0;
    last_e   = 1'b0;
    if (idx_q == '0) begin
      err_e  = ~bus.sdm__sdf__dcntl[0];
      last_e = bus.sdm__sdf__dcntl[1] | err_e;
    end else begin
      err_e = bus.sdm__sdf__dcntl[0];
      if (idx_q == IDX_W'(MAX_LEN-1) && bus.sdm__sdf__dcntl != DC_EOM) begin
        err_e = 1'b1;
      end
      last_e = err_e | (bus.sdm__sdf__dcntl == DC_EOM);
    end
    last_now = live_now & last_e;
    err_now  = live_now & err_e;
  end

  // The read that would coincide with the terminating entry is never issued
  assign issue = (state_q == ISSUE) && !last_now;

  // Next-state, counters and live-bit tracking
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    tag_d   = tag_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    done_d  = done_q;

    live_d[0] = issue;
    for (int i = 1; i < RD_LAT; i++) begin
      live_d[i] = live_q[i-1];
    end
    if (last_now) begin
      live_d = '0;
    end

    // Every response retires one in-flight read, squashed or not
    ifl_d = ifl_q + IFL_W'(issue)
                  - IFL_W'(bus.sdm__sdf__valid && (ifl_q != '0));

    if (live_now) idx_d = idx_q + 1'b1;
    if (last_now) done_d = 1'b1;
    if (issue)    cnt_d = cnt_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (grant) begin
          state_d = ISSUE;
          tag_d   = gnt_idx;
          ptr_d   = req_ptr_a[gnt_idx];
          rr_d    = (gnt_idx == TAG_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
          cnt_d   = '0;
          idx_d   = '0;
          done_d  = 1'b0;
        end
      end
      ISSUE: begin
        if (last_now) begin
          state_d = (ifl_d == '0) ? IDLE : DRAIN;
        end else if (cnt_q == CNT_W'(MAX_LEN-1)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if ((done_q || last_now) && ifl_d == '0) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      state_q <= IDLE;
      rr_q    <= '0;
      tag_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      ifl_q   <= '0;
      live_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      tag_q   <= tag_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      ifl_q   <= ifl_d;
      live_q  <= live_d;
      done_q  <= done_d;
    end
  end

  assign bus.sdf__xx__req_ready = grant ? (NUM_REQ'(1) << gnt_idx) : '0;
  assign bus.sdf__sdm__read     = issue;
  assign bus.sdf__sdm__addr     = issue ? (ptr_q + ADDR_W'(cnt_q)) : '0;
  assign bus.sdf__xx__valid     = live_now;
  assign bus.sdf__xx__tag       = live_now ? tag_q : '0;
  assign bus.sdf__xx__last      = last_now;
  assign bus.sdf__xx__err       = err_now;

endmodule

// File: tb/tb_sd_fetch_cntl.sv
// Testbench for sd_fetch_cntl: a behavioural sd_memory with fixed read latency,
// a table of single-descriptor jobs, and hand-written round-robin and reset runs.
module tb_sd_fetch_cntl;

  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 10;
  localparam int MAX_LEN = 16;
  localparam int RD_LAT  = 2;

  typedef struct {
    int          tag;
    logic [9:0]  ptr;
    int          nmem;
    logic [31:0] pat;
    int          exp_n;
    int          exp_reads;
    bit          exp_err;
  } job_t;

  typedef struct {
    int tag;
    bit last;
    bit err;
  } ent_t;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   last_cyc = -1;

  ent_t exp_ent [$];
  int   exp_rd  [$];
  int   exp_gnt [$];
  job_t jobs    [10];

  logic [1:0] mem [1024];
  logic       p1_v = 1'b0;
  logic       p2_v = 1'b0;
  logic [9:0] p1_a = '0;
  logic [9:0] p2_a = '0;

  sd_fetch_cntl_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W)) bus ();

  sd_fetch_cntl #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .MAX_LEN(MAX_LEN), .RD_LAT(RD_LAT)
  ) dut (
    .clk           (clk),
    .reset_poweron (rst_n),
    .bus           (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // sd_memory model: data returns RD_LAT cycles after the read strobe
  always @(posedge clk) begin
    p1_v <= bus.sdf__sdm__read;
    p1_a <= bus.sdf__sdm__addr;
    p2_v <= p1_v;
    p2_a <= p1_a;
  end
  assign bus.sdm__sdf__valid = p2_v;
  assign bus.sdm__sdf__dcntl = mem[p2_a];

  task automatic chk(input string nm, input int act, input int exp_v);
    n_tests++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  task automatic unexpected(input string nm, input int act);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got 0x%0h, expected nothing (t=%0t)", nm, act, $time);
  endtask

  // Scoreboard: grants, read addresses and tagged entries against queued expectations
  always @(negedge clk) begin
    ent_t e;
    int   g;
    if (bus.sdf__xx__req_ready != '0) begin
      if (exp_gnt.size() == 0) unexpected("grant_extra", int'(bus.sdf__xx__req_ready));
      else begin
        g = exp_gnt.pop_front();
        chk("grant", int'(bus.sdf__xx__req_ready), 1 << g);
      end
    end
    if (bus.sdf__sdm__read) begin
      if (exp_rd.size() == 0) unexpected("read_extra", int'(bus.sdf__sdm__addr));
      else chk("rd_addr", int'(bus.sdf__sdm__addr), exp_rd.pop_front());
    end
    if (bus.sdf__xx__valid) begin
      if (exp_ent.size() == 0) unexpected("entry_extra", int'(bus.sdf__xx__tag));
      else begin
        e = exp_ent.pop_front();
        chk("ent_tag",  int'(bus.sdf__xx__tag),  e.tag);
        chk("ent_last", int'(bus.sdf__xx__last), int'(e.last));
        chk("ent_err",  int'(bus.sdf__xx__err),  int'(e.err));
        if (bus.sdf__xx__last) last_cyc = cyc;
      end
    end else if (bus.sdf__xx__last || bus.sdf__xx__err) begin
      unexpected("flag_no_valid", {30'd0, bus.sdf__xx__last, bus.sdf__xx__err});
    end
  end

  task automatic flush_all();
    exp_ent.delete();
    exp_rd.delete();
    exp_gnt.delete();
  endtask

  task automatic wait_entries(input string nm, input int budget);
    for (int b = 0; b < budget && exp_ent.size() != 0; b++) begin
      @(posedge clk); #1;
    end
    if (exp_ent.size() != 0) begin
      unexpected({nm, "_timeout"}, exp_ent.size());
      flush_all();
    end
  endtask

  task automatic run_job(input job_t j);
    int   g_cyc;
    bit   seen;
    ent_t e;
    for (int i = 0; i < j.nmem; i++) mem[(int'(j.ptr) + i) & 1023] = j.pat[2*i +: 2];
    exp_gnt.push_back(j.tag);
    for (int i = 0; i < j.exp_reads; i++) exp_rd.push_back((int'(j.ptr) + i) & 1023);
    for (int i = 0; i < j.exp_n; i++) begin
      e.tag  = j.tag;
      e.last = (i == j.exp_n - 1);
      e.err  = (i == j.exp_n - 1) && j.exp_err;
      exp_ent.push_back(e);
    end
    last_cyc = -1;
    @(posedge clk); #1;
    bus.xx__sdf__req_ptr[j.tag*ADDR_W +: ADDR_W] = j.ptr;
    bus.xx__sdf__req_valid[j.tag] = 1'b1;
    seen  = 1'b0;
    g_cyc = 0;
    for (int b = 0; b < 40 && !seen; b++) begin
      @(negedge clk);
      if (bus.sdf__xx__req_ready[j.tag]) begin
        seen  = 1'b1;
        g_cyc = cyc;
      end
    end
    @(posedge clk); #1;
    bus.xx__sdf__req_valid = '0;
    if (!seen) begin
      unexpected("grant_timeout", j.tag);
      flush_all();
      return;
    end
    wait_entries("entries", 60);
    chk("latency", last_cyc - g_cyc, j.exp_n + RD_LAT);
    repeat (6) @(posedge clk);
    #1;
    chk("reads_left", exp_rd.size(), 0);
    exp_rd.delete();
  endtask

  initial begin : main
    ent_t e;
    int   ng;

    jobs[0] = '{tag:0, ptr:10'h010, nmem:3,  pat:32'h0000_0021, exp_n:3,  exp_reads:4,  exp_err:1'b0};
    jobs[1] = '{tag:1, ptr:10'h3FE, nmem:4,  pat:32'h0000_0081, exp_n:4,  exp_reads:5,  exp_err:1'b0};
    jobs[2] = '{tag:0, ptr:10'h100, nmem:2,  pat:32'h0000_000C, exp_n:1,  exp_reads:2,  exp_err:1'b1};
    jobs[3] = '{tag:1, ptr:10'h120, nmem:1,  pat:32'h0000_0003, exp_n:1,  exp_reads:2,  exp_err:1'b0};
    jobs[4] = '{tag:0, ptr:10'h140, nmem:16, pat:32'h0000_0001, exp_n:16, exp_reads:16, exp_err:1'b1};
    jobs[5] = '{tag:1, ptr:10'h160, nmem:3,  pat:32'h0000_0011, exp_n:3,  exp_reads:4,  exp_err:1'b1};
    jobs[6] = '{tag:0, ptr:10'h180, nmem:16, pat:32'h8000_0001, exp_n:16, exp_reads:16, exp_err:1'b0};
    jobs[7] = '{tag:1, ptr:10'h1A0, nmem:2,  pat:32'h0000_000D, exp_n:2,  exp_reads:3,  exp_err:1'b1};
    jobs[8] = '{tag:1, ptr:10'h1C0, nmem:2,  pat:32'h0000_0009, exp_n:2,  exp_reads:3,  exp_err:1'b0};
    jobs[9] = '{tag:0, ptr:10'h1E0, nmem:4,  pat:32'h0000_0081, exp_n:4,  exp_reads:5,  exp_err:1'b0};

    for (int i = 0; i < 1024; i++) mem[i] = 2'b11;
    bus.xx__sdf__req_valid = '0;
    bus.xx__sdf__req_ptr   = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;

    // Reset: requests present but nothing granted, all outputs low
    bus.xx__sdf__req_valid = 2'b11;
    repeat (2) @(negedge clk);
    chk("rst_ready", int'(bus.sdf__xx__req_ready), 0);
    chk("rst_read",  int'(bus.sdf__sdm__read), 0);
    chk("rst_addr",  int'(bus.sdf__sdm__addr), 0);
    chk("rst_valid", int'(bus.sdf__xx__valid), 0);
    chk("rst_last",  int'(bus.sdf__xx__last), 0);
    chk("rst_err",   int'(bus.sdf__xx__err), 0);
    bus.xx__sdf__req_valid = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Both requesters held: grants alternate 0,1,0,1
    mem[10'h300] = 2'b11;
    mem[10'h310] = 2'b11;
    for (int r = 0; r < 4; r++) begin
      exp_gnt.push_back(r % 2);
      exp_rd.push_back((r % 2) ? 10'h310 : 10'h300);
      exp_rd.push_back((r % 2) ? 10'h311 : 10'h301);
      e.tag = r % 2; e.last = 1'b1; e.err = 1'b0;
      exp_ent.push_back(e);
    end
    @(posedge clk); #1;
    bus.xx__sdf__req_ptr   = {10'h310, 10'h300};
    bus.xx__sdf__req_valid = 2'b11;
    ng = 0;
    for (int b = 0; b < 80 && ng < 4; b++) begin
      @(negedge clk);
      if (bus.sdf__xx__req_ready != '0) ng++;
    end
    @(posedge clk); #1;
    bus.xx__sdf__req_valid = '0;
    chk("rr_grants", ng, 4);
    wait_entries("rr_entries", 40);
    repeat (6) @(posedge clk);
    #1;
    chk("rr_reads_left", exp_rd.size(), 0);
    exp_rd.delete();

    // Table of single descriptors
    for (int i = 0; i < 10; i++) run_job(jobs[i]);

    // Reset after two reads: abandon, squash late responses, then refetch
    mem[10'h200] = 2'b01; mem[10'h201] = 2'b00;
    mem[10'h202] = 2'b00; mem[10'h203] = 2'b10;
    exp_gnt.push_back(0);
    exp_rd.push_back(10'h200);
    exp_rd.push_back(10'h201);
    @(posedge clk); #1;
    bus.xx__sdf__req_ptr[0 +: ADDR_W] = 10'h200;
    bus.xx__sdf__req_valid = 2'b01;
    ng = 0;
    for (int b = 0; b < 40 && ng == 0; b++) begin
      @(negedge clk);
      if (bus.sdf__xx__req_ready[0]) ng = 1;
    end
    chk("rst5_grant", ng, 1);
    @(posedge clk); #1;
    bus.xx__sdf__req_valid = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus.xx__sdf__req_ptr[ADDR_W +: ADDR_W] = 10'h210;
    bus.xx__sdf__req_valid = 2'b10;
    #1;
    chk("rst5_read",  int'(bus.sdf__sdm__read), 0);
    chk("rst5_ready", int'(bus.sdf__xx__req_ready), 0);
    chk("rst5_valid", int'(bus.sdf__xx__valid), 0);
    chk("rst5_last",  int'(bus.sdf__xx__last), 0);
    @(posedge clk); #1;
    bus.xx__sdf__req_valid = '0;
    rst_n = 1'b1;
    #1;
    chk("rst5_late_valid", int'(bus.sdf__xx__valid), 0);
    chk("rst5_late_err",   int'(bus.sdf__xx__err), 0);
    chk("rst5_reads_left", exp_rd.size(), 0);
    exp_rd.delete();
    exp_gnt.delete();
    repeat (3) @(posedge clk);
    run_job('{tag:0, ptr:10'h200, nmem:4, pat:32'h0000_0081, exp_n:4, exp_reads:5, exp_err:1'b0});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
